byte_frame_tx: RTL and testbench
================================

# byte_frame_tx

Serial framing stage that consumes the 8-bit byte produced by the upstream 8-bit register stage and transmits it on a single line. The frame is a start bit, 8 data bits LSB-first, an optional even-parity bit and a stop bit, with each bit held for a programmable number of clock cycles. A valid/ready handshake throttles the upstream producer: one byte is accepted per frame, and there is no internal queue.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range ≥1.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- d  input  8  byte to transmit; sampled only on the accept edge.
- d_valid  input  1  upstream asserts when d holds a byte to send.
- d_ready  output  1  registered; high only in IDLE.
- txd  output  1  registered serial line; idle level 1.
- busy  output  1  registered; high in every state except IDLE.
- frame_done  output  1  registered one-cycle pulse when a frame completes.

## Operation
- Reset (asynchronous, immediate): state=IDLE, txd=1, d_ready=1, busy=0, frame_done=0, bit counter=0, cycle counter=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd=1. On an edge with d_valid=1 (d_ready=1 is implied):
  - latch d into the shift register;
  - compute parity = XOR of d;
  - go to START with txd<=0, d_ready<=0, busy<=1.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with txd<=d[0].
- DATA: output the shift-register LSB for CLKS_PER_BIT cycles per bit, shifting right after each bit, for 8 bits.
  - After bit 7, go to PARITY if PARITY_EN=1 (txd<=parity).
  - Otherwise go to STOP (txd<=1).
- PARITY: txd=parity for CLKS_PER_BIT cycles (even parity: total count of ones over data+parity is even), then go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. On the last cycle's edge, go to IDLE with d_ready<=1, busy<=0, frame_done<=1. frame_done clears on the next edge.
- The cycle counter runs 0..CLKS_PER_BIT-1 and advances the bit when it reaches CLKS_PER_BIT-1. The bit counter is 3 bits wide (0..7).
- d_valid while d_ready=0 is ignored, not stored. Changes on d after the accept edge have no effect on the frame in flight.
- Reset during a frame aborts it: txd returns to 1 immediately, the byte is lost, and no frame_done is issued.

## Timing
- Accept edge E0 is the edge where d_valid=1 and d_ready=1.
- Frame length is F = (10 + PARITY_EN) × CLKS_PER_BIT cycles, occupying the cycles after E0 through edge E0+F.
- Start bit is low for cycles E0..E0+CLKS_PER_BIT. Data bit i occupies [E0+(1+i)·CLKS_PER_BIT, E0+(2+i)·CLKS_PER_BIT).
- At edge E0+F: IDLE, d_ready=1, frame_done=1 (one cycle).
- Back-to-back: if d_valid=1 during that IDLE cycle, the next accept is edge E0+F+1. The minimum line-high time between frames is therefore CLKS_PER_BIT+1 cycles, and throughput is one byte per F+1 cycles.
- CLKS_PER_BIT=1: every bit lasts exactly one cycle, with no extra stall cycles.
- Simultaneous reset and d_valid: reset wins and no byte is accepted.

## Test plan
- Reset check: assert reset mid-cycle (asynchronous) → txd=1, d_ready=1, busy=0, frame_done=0 before the next clk edge.
- Single frame, CLKS_PER_BIT=4, PARITY_EN=1, d=0xA5 → txd stream 0,1,0,1,0,0,1,0,1,0(parity),1, each bit held 4 cycles. busy high 44 cycles, then frame_done pulse for exactly 1 cycle and d_ready=1.
- Parity odd-weight byte, d=0x07 → parity bit=1. With PARITY_EN=0, d=0x07 → 40-cycle frame with no parity bit.
- Back-to-back: d_valid held high with d=0x3C then 0xC3 → second start bit begins exactly F+1=45 cycles after the first. Both frames are bit-correct.
- Handshake hold-off: toggle d and d_valid during a frame of 0x55 → transmitted bits remain 0x55 and no extra byte is accepted.
- Reset mid-DATA (after bit 3 of 0xFF) → txd=1 immediately, no frame_done. A new byte 0x81 after reset transmits cleanly.

Source files
------------

// File: rtl/byte_frame_tx_if.sv
// Purpose: groups the byte handshake and serial-line outputs of byte_frame_tx.
// Latency: none, wiring only.
// Backpressure: d_ready from the slave throttles d_valid/d from the master.
// Ports (slave view):
//   d[7:0], d_valid      in   byte offered by the upstream register stage
//   d_ready              out  byte accepted on an edge where both are high
//   txd, busy, frame_done out serial line and frame status
interface byte_frame_tx_if;
    logic [7:0] d;
    logic       d_valid;
    logic       d_ready;
    logic       txd;
    logic       busy;
    logic       frame_done;

    modport master (
        output d, d_valid,
        input  d_ready, txd, busy, frame_done
    );

    modport slave (
        input  d, d_valid,
        output d_ready, txd, busy, frame_done
    );
endinterface

// File: rtl/byte_frame_tx.sv
// Purpose: serialises one byte per frame: start, 8 data bits LSB-first, optional even parity, stop.
// Latency: txd drops on the accept edge; frame lasts (10+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: d_ready is high only in IDLE; d_valid at any other time is ignored, not stored.
// Ports: clk, reset (async, active-high); bus (slave modport) carries d, d_valid, d_ready,
//        txd (idle high), busy (high outside IDLE), frame_done (one-cycle pulse at frame end).
module byte_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic           clk,
    input  logic           reset,
    byte_frame_tx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             txd_q, txd_d;
    logic             d_ready_q, d_ready_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             bit_end;

    // Every bit period ends on the last cycle-counter value.
    assign bit_end = (cyc_cnt_q == CYC_LAST);

    always_comb begin
        state_d      = state_q;
        cyc_cnt_d    = cyc_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        txd_d        = txd_q;
        d_ready_d    = d_ready_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        // Outside IDLE the cycle counter free-runs through each bit period.
        if (state_q != S_IDLE) begin
            cyc_cnt_d = bit_end ? '0 : cyc_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (bus.d_valid) begin
                    shift_d   = bus.d;
                    parity_d  = ^bus.d;
                    cyc_cnt_d = '0;
                    bit_cnt_d = '0;
                    txd_d     = 1'b0;
                    d_ready_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_d   = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            txd_d   = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        // Present the next bit now; the shift keeps it at the LSB.
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    d_ready_d    = 1'b1;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                txd_d     = 1'b1;
                d_ready_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cyc_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            txd_q        <= 1'b1;
            d_ready_q    <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_cnt_q    <= cyc_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            txd_q        <= txd_d;
            d_ready_q    <= d_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.txd        = txd_q;
    assign bus.d_ready    = d_ready_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_byte_frame_tx.sv
module tb_byte_frame_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    byte_frame_tx_if bus_a ();
    byte_frame_tx_if bus_b ();
    byte_frame_tx_if bus_c ();

    logic [7:0] d_drv;
    logic       dv_drv;
    int         sel;

    assign bus_a.d       = d_drv;
    assign bus_b.d       = d_drv;
    assign bus_c.d       = d_drv;
    assign bus_a.d_valid = dv_drv && (sel == 0);
    assign bus_b.d_valid = dv_drv && (sel == 1);
    assign bus_c.d_valid = dv_drv && (sel == 2);

    byte_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    byte_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
    byte_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

    logic o_txd, o_rdy, o_busy, o_done;
    int   cpb, pe;

    always_comb begin
        o_txd  = bus_a.txd;
        o_rdy  = bus_a.d_ready;
        o_busy = bus_a.busy;
        o_done = bus_a.frame_done;
        cpb    = 4;
        pe     = 1;
        if (sel == 1) begin
            o_txd  = bus_b.txd;
            o_rdy  = bus_b.d_ready;
            o_busy = bus_b.busy;
            o_done = bus_b.frame_done;
            pe     = 0;
        end else if (sel == 2) begin
            o_txd  = bus_c.txd;
            o_rdy  = bus_c.d_ready;
            o_busy = bus_c.busy;
            o_done = bus_c.frame_done;
            cpb    = 1;
        end
    end

    int errors = 0;
    int checks = 0;

    // Frame bit index 0 = start, 1..8 = data LSB first, then parity (if enabled), then stop.
    function automatic logic exp_bit(input logic [7:0] b, input int par_en, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && par_en != 0) return ^b;
        return 1'b1;
    endfunction

    // Offers one byte for a single cycle; returns #1 after the accept edge.
    task automatic accept(input logic [7:0] b);
        @(posedge clk);
        #1;
        d_drv  = b;
        dv_drv = 1'b1;
        @(posedge clk);
        #1;
        dv_drv = 1'b0;
    endtask

    // Called just after the accept edge; returns at the negedge following the final edge.
    task automatic expect_frame(input logic [7:0] b, input string nm);
        int f;
        f = (10 + pe) * cpb;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            checks++;
            if (o_txd !== exp_bit(b, pe, k / cpb)) begin
                errors++;
                $display("FAIL %s txd cycle %0d: got %b want %b", nm, k, o_txd, exp_bit(b, pe, k / cpb));
            end
            checks++;
            if ({o_busy, o_rdy, o_done} !== 3'b100) begin
                errors++;
                $display("FAIL %s status cycle %0d: busy/rdy/done got %b want 100", nm, k, {o_busy, o_rdy, o_done});
            end
        end
        @(negedge clk);
        checks++;
        if ({o_busy, o_rdy, o_done, o_txd} !== 4'b0111) begin
            errors++;
            $display("FAIL %s end: busy/rdy/done/txd got %b want 0111", nm, {o_busy, o_rdy, o_done, o_txd});
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        dv_drv = 1'b0;
        d_drv  = 8'h00;
        sel    = 0;
        #2;
        checks++;
        if ({bus_a.txd, bus_a.d_ready, bus_a.busy, bus_a.frame_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_a: got %b want 1100", {bus_a.txd, bus_a.d_ready, bus_a.busy, bus_a.frame_done});
        end
        checks++;
        if ({bus_b.txd, bus_b.d_ready, bus_b.busy, bus_b.frame_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_b: got %b want 1100", {bus_b.txd, bus_b.d_ready, bus_b.busy, bus_b.frame_done});
        end
        checks++;
        if ({bus_c.txd, bus_c.d_ready, bus_c.busy, bus_c.frame_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_c: got %b want 1100", {bus_c.txd, bus_c.d_ready, bus_c.busy, bus_c.frame_done});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        sel = 0;
        accept(8'hA5);
        expect_frame(8'hA5, "single_a5");
        @(negedge clk);
        checks++;
        if ({o_done, o_busy, o_rdy} !== 3'b001) begin
            errors++;
            $display("FAIL single_a5 pulse: done/busy/rdy got %b want 001", {o_done, o_busy, o_rdy});
        end
    endtask

    task automatic test_parity();
        sel = 0;
        accept(8'h07);
        expect_frame(8'h07, "parity_07");
        sel = 1;
        accept(8'h07);
        expect_frame(8'h07, "nopar_07");
        @(negedge clk);
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL nopar_07 pulse: done/busy got %b want 00", {o_done, o_busy});
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        @(posedge clk);
        #1;
        d_drv  = 8'h3C;
        dv_drv = 1'b1;
        @(posedge clk);
        #1;
        d_drv = 8'hC3;
        expect_frame(8'h3C, "b2b_first");
        @(posedge clk);
        #1;
        dv_drv = 1'b0;
        expect_frame(8'hC3, "b2b_second");
        @(negedge clk);
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b tail: done/busy got %b want 00", {o_done, o_busy});
        end
    endtask

    task automatic test_holdoff();
        sel = 0;
        accept(8'h55);
        fork
            expect_frame(8'h55, "holdoff_55");
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    d_drv  = ~d_drv ^ 8'h3C;
                    dv_drv = ~dv_drv;
                end
                dv_drv = 1'b0;
            end
        join
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_busy !== 1'b0) begin
                errors++;
                $display("FAIL holdoff extra accept: busy got %b want 0", o_busy);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_seen;
        sel = 0;
        accept(8'hFF);
        repeat (21) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst busy before reset: got %b want 1", o_busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({o_txd, o_rdy, o_busy, o_done} !== 4'b1100) begin
            errors++;
            $display("FAIL midrst async: txd/rdy/busy/done got %b want 1100", {o_txd, o_rdy, o_busy, o_done});
        end
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL midrst aborted frame: done/busy cycles got %0d want 0", done_seen);
        end
        accept(8'h81);
        expect_frame(8'h81, "midrst_81");
    endtask

    task automatic test_cpb1();
        sel = 2;
        accept(8'hA5);
        expect_frame(8'hA5, "cpb1_a5");
        @(negedge clk);
        checks++;
        if ({o_done, o_busy, o_txd} !== 3'b001) begin
            errors++;
            $display("FAIL cpb1 tail: done/busy/txd got %b want 001", {o_done, o_busy, o_txd});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_holdoff();
        test_reset_mid_frame();
        test_cpb1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
